// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared definitions for the frame-memory arbiter:
//   - default address/pixel widths, host FIFO depth and last clear address
//   - arbiter FSM state type
//   - pixel and address typedefs at the default widths
//   - helper returning the width of a 0..depth occupancy counter
// -----------------------------------------------------------------------------
package vmem_pkg;

   localparam int DEF_ADDR_W     = 19;      // {h[9:0], v[8:0]}
   localparam int DEF_DATA_W     = 24;      // 8R/8G/8B
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_CLR_LAST   = 524287;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef logic [DEF_DATA_W-1:0] pixel_t;
   typedef logic [DEF_ADDR_W-1:0] vaddr_t;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vmem_wr_fifo.sv
// -----------------------------------------------------------------------------
// vmem_wr_fifo
// Small synchronous FIFO buffering host pixel writes until the memory port is
// free. The head entry is presented combinationally so the arbiter can write
// it to memory in the same cycle it pops it.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   push          write push_data (ignored when full or flushing)
//   push_data     entry to enqueue
//   pop           drop head entry (ignored when empty or flushing)
//   flush         discard every entry, including a same-cycle push
//   head_data     current head entry (valid when !empty)
//   full, empty   occupancy flags
//   level         number of entries held
// -----------------------------------------------------------------------------
module vmem_wr_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign head_data = store_q[rd_ptr_q];

   // Flush wins over everything so a write accepted alongside it is lost.
   assign do_push = push & ~full  & ~flush;
   assign do_pop  = pop  & ~empty & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) store_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/vmem_arbiter.sv
// -----------------------------------------------------------------------------
// vmem_arbiter
// Single access point to the single-port frame memory. Each cycle exactly one
// user is granted, in priority order: display read, clear engine, host FIFO.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   rd_en, rd_addr           display read request (never stalled)
//   rd_data, rd_data_valid   read return, one cycle after rd_en
//   wr_valid/wr_ready        host write handshake, wr_addr/wr_data payload
//   clr_start, clr_data      start a fill of 0..CLR_LAST with clr_data
//   clr_busy                 fill in progress
//   fifo_level               host FIFO occupancy
//   mem_en/we/addr/wdata     memory command, mem_rdata synchronous read data
// -----------------------------------------------------------------------------
module vmem_arbiter
   import vmem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int CLR_LAST   = DEF_CLR_LAST,
   localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int ENTRY_W = ADDR_W + DATA_W;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0] clr_val_q, clr_val_d;
   logic              rd_valid_q;

   logic               clr_accept;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;

   // ---------------------------------------------------------------- FIFO
   assign wr_ready  = resetn & (state_q == IDLE) & ~fifo_full;
   assign fifo_push = wr_valid & wr_ready;

   vmem_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fifo_push),
      .push_data ({wr_addr, wr_data}),
      .pop       (fifo_pop),
      .flush     (clr_accept),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // ------------------------------------------------------ state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         clr_addr_q <= '0;
         clr_val_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         clr_val_q  <= clr_val_d;
         rd_valid_q <= rd_en;
      end
   end

   // ------------------------------------------------------ next state
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_val_d  = clr_val_q;
      clr_accept = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
               clr_val_d  = clr_data;
               clr_accept = 1'b1;
            end
         end
         CLEAR: begin
            // The fill only advances on cycles the display leaves free.
            if (!rd_en) begin
               if (clr_addr_q == ADDR_W'(CLR_LAST)) begin
                  state_d    = IDLE;
                  clr_addr_d = '0;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------ outputs
   // One grant per cycle; everything is held at zero while in reset so the
   // memory sees no command even if rd_en is asserted.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fifo_pop  = 1'b0;
      if (resetn) begin
         if (rd_en) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
         end else if (state_q == CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = clr_val_q;
         end else if (!fifo_empty) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_head[ENTRY_W-1 -: ADDR_W];
            mem_wdata = fifo_head[DATA_W-1:0];
            fifo_pop  = 1'b1;
         end
      end
   end

   assign clr_busy      = (state_q == CLEAR);
   assign rd_data_valid = rd_valid_q;
   assign rd_data       = resetn ? mem_rdata : '0;

endmodule

// File: tb/tb_vmem_arbiter.sv
module tb_vmem_arbiter;
   import vmem_pkg::*;

   localparam int AW    = 19;
   localparam int DW    = 24;
   localparam int DEPTH = 8;
   localparam int LAST  = 15;
   localparam int LW    = $clog2(DEPTH + 1);

   typedef struct packed {
      vaddr_t addr;
      pixel_t data;
   } wr_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          clr_start;
   logic [DW-1:0] clr_data;
   logic          clr_busy;
   logic [LW-1:0] fifo_level;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   wr_t exp_q[$];
   wr_t obs_q[$];
   logic [DW-1:0] mem_model [1024];

   vmem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLR_LAST(LAST)
   ) dut (
      .clk(clk), .resetn(resetn),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
      .fifo_level(fifo_level),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory model plus write monitor.
   always @(posedge clk) begin
      if (resetn && mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[9:0]];
      if (resetn && mem_en && mem_we) begin
         mem_model[mem_addr[9:0]] <= mem_wdata;
         obs_q.push_back('{addr: mem_addr, data: mem_wdata});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      wr_t e;
      wr_t o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_missing actual=none required=addr 0x%0h data 0x%0h", tag, e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("memwr %s addr=0x%0h data=0x%0h", tag, o.addr, o.data);
            chk({tag, "_addr"}, 64'(o.addr), 64'(e.addr));
            chk({tag, "_data"}, 64'(o.data), 64'(e.data));
         end
      end
      chk({tag, "_extra_writes"}, 64'(obs_q.size()), 64'd0);
      obs_q.delete();
   endtask

   // Offer one host write and wait (bounded) for its acceptance.
   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit commit);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (wr_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         $display("host wr addr=0x%0h data=0x%0h", a, d);
         if (commit) exp_q.push_back('{addr: a, data: d});
      end else begin
         checks++;
         errors++;
         $display("FAIL host_write_timeout actual=wr_ready 0 required=wr_ready 1");
      end
   endtask

   task automatic host_idle();
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Step through a clear from its first CLEAR cycle, counting busy cycles.
   task automatic run_clear(input bit toggle, output int busy);
      bit prev_rd;
      busy    = 0;
      prev_rd = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) @(negedge clk);
         rd_en     = toggle ? (c % 2 == 0) : 1'b0;
         rd_addr   = AW'(c);
         clr_start = toggle && (c == 5);
         if (toggle && c == 5) clr_data = 24'h123123;
         #1;
         if (!clr_busy) break;
         busy++;
         chk("clr_wr_ready_low", 64'(wr_ready), 64'd0);
         if (rd_en) chk("clr_read_grant", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, AW'(c)}));
         else       chk("clr_write_grant", 64'({mem_en, mem_we}), 64'(2'b11));
         if (toggle) chk("clr_rd_valid", 64'(rd_data_valid), 64'(prev_rd));
         prev_rd = rd_en;
      end
      rd_en     = 1'b0;
      clr_start = 1'b0;
   endtask

   wr_t vec [6];
   int  busy;
   bit  found;

   initial begin
      vec[0] = '{addr: 19'h00005, data: 24'hABCDEF};
      vec[1] = '{addr: 19'h00000, data: 24'h123456};
      vec[2] = '{addr: 19'h0000F, data: 24'hFFFFFF};
      vec[3] = '{addr: 19'h00064, data: 24'h000000};
      vec[4] = '{addr: 19'h003FF, data: 24'hA5A5A5};
      vec[5] = '{addr: 19'h00007, data: 24'h010203};

      // ---- reset: every output held at zero even with requests asserted
      resetn    = 1'b0;
      rd_en     = 1'b1;
      rd_addr   = 19'h5;
      wr_valid  = 1'b1;
      wr_addr   = 19'h9;
      wr_data   = 24'h999999;
      clr_start = 1'b1;
      clr_data  = 24'h777777;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_clr_busy",   64'(clr_busy), 64'd0);
      chk("rst_rd_valid",   64'(rd_data_valid), 64'd0);
      chk("rst_rd_data",    64'(rd_data), 64'd0);
      chk("rst_fifo_level", 64'(fifo_level), 64'd0);
      chk("rst_wr_ready",   64'(wr_ready), 64'd0);
      chk("rst_mem_cmd",    64'({mem_en, mem_we}), 64'd0);
      chk("rst_mem_addr",   64'(mem_addr), 64'd0);
      chk("rst_mem_wdata",  64'(mem_wdata), 64'd0);
      @(negedge clk);
      rd_en = 1'b0; wr_valid = 1'b0; clr_start = 1'b0;
      resetn = 1'b1;
      #1;
      chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);

      // ---- table: preload through host port, then back-to-back reads
      foreach (vec[i]) host_write(vec[i].addr, vec[i].data, 1'b1);
      host_idle();
      repeat (3) @(negedge clk);
      check_writes("preload");
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i < 6) begin
            rd_en   = 1'b1;
            rd_addr = vec[i].addr;
         end else begin
            rd_en = 1'b0;
         end
         #1;
         if (i < 6) chk("rd_grant", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, vec[i].addr}));
         if (i > 0) begin
            $display("read addr=0x%0h data=0x%0h valid=%0d", vec[i-1].addr, rd_data, rd_data_valid);
            chk("rd_valid", 64'(rd_data_valid), 64'd1);
            chk("rd_data",  64'(rd_data), 64'(vec[i-1].data));
         end
      end
      @(negedge clk);
      #1;
      chk("rd_valid_drop", 64'(rd_data_valid), 64'd0);

      // ---- reads hold off host writes; drain in order once reads stop
      rd_en = 1'b1;
      rd_addr = 19'h5;
      host_write(19'd1, 24'h111111, 1'b1);
      host_write(19'd2, 24'h222222, 1'b1);
      host_write(19'd3, 24'h333333, 1'b1);
      host_idle();
      #1;
      chk("hold_level3", 64'(fifo_level), 64'd3);
      chk("hold_no_writes", 64'(obs_q.size()), 64'd0);
      @(negedge clk);
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("drain_level1", 64'(fifo_level), 64'd1);
      @(negedge clk);
      #1;
      chk("drain_level0", 64'(fifo_level), 64'd0);
      check_writes("drain");

      // ---- fill the FIFO; the 9th write waits for the first pop
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) host_write(AW'(32 + i), DW'(24'h100000 + i), 1'b1);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = 19'd40;
      wr_data  = 24'h0F0F0F;
      #1;
      chk("full_wr_ready", 64'(wr_ready), 64'd0);
      chk("full_level", 64'(fifo_level), 64'd8);
      @(negedge clk);
      rd_en = 1'b0;
      #1;
      chk("full_pop_cycle_ready", 64'(wr_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("after_pop_ready", 64'(wr_ready), 64'd1);
      chk("after_pop_level", 64'(fifo_level), 64'd7);
      @(posedge clk);
      exp_q.push_back('{addr: 19'd40, data: 24'h0F0F0F});
      host_idle();
      repeat (12) @(negedge clk);
      #1;
      chk("full_drain_level", 64'(fifo_level), 64'd0);
      check_writes("full");

      // ---- clear flushes queued writes and fills 0..LAST
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) host_write(AW'(64 + i), DW'(24'hC00000 + i), 1'b0);
      host_idle();
      #1;
      chk("pre_clr_level", 64'(fifo_level), 64'd4);
      @(negedge clk);
      clr_start = 1'b1;
      clr_data  = 24'h00FF00;
      wr_valid  = 1'b1;
      wr_addr   = 19'd80;
      wr_data   = 24'hDEAD01;
      #1;
      chk("clr_start_ready", 64'(wr_ready), 64'd1);
      for (int a = 0; a <= LAST; a++) exp_q.push_back('{addr: AW'(a), data: 24'h00FF00});
      @(negedge clk);
      clr_start = 1'b0;
      wr_valid  = 1'b0;
      rd_en     = 1'b0;
      #1;
      chk("clr_flush_level", 64'(fifo_level), 64'd0);
      run_clear(1'b0, busy);
      chk("clr_busy_cycles", 64'(busy), 64'd16);
      check_writes("clear");

      // ---- clear interleaved with reads; second start ignored
      @(negedge clk);
      clr_start = 1'b1;
      clr_data  = 24'h0000AA;
      for (int a = 0; a <= LAST; a++) exp_q.push_back('{addr: AW'(a), data: 24'h0000AA});
      @(negedge clk);
      clr_start = 1'b0;
      run_clear(1'b1, busy);
      chk("clr_toggle_cycles", 64'(busy), 64'd32);
      chk("clr_toggle_idle_ready", 64'(wr_ready), 64'd1);
      check_writes("clear_toggle");

      // ---- reset in the middle of a clear
      @(negedge clk);
      clr_start = 1'b1;
      clr_data  = 24'h5A5A5A;
      for (int a = 0; a < 7; a++) exp_q.push_back('{addr: AW'(a), data: 24'h5A5A5A});
      @(negedge clk);
      clr_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (mem_en && mem_we && mem_addr == 19'd7) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("abort_reached_addr7", 64'(found), 64'd1);
      resetn = 1'b0;
      #1;
      chk("abort_clr_busy", 64'(clr_busy), 64'd0);
      chk("abort_mem_en", 64'(mem_en), 64'd0);
      chk("abort_wr_ready", 64'(wr_ready), 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("abort_rel_busy", 64'(clr_busy), 64'd0);
      chk("abort_rel_ready", 64'(wr_ready), 64'd1);
      chk("abort_rel_mem_en", 64'(mem_en), 64'd0);
      repeat (2) @(negedge clk);
      check_writes("abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
Shares the single-port frame memory (19-bit {h_addr, v_addr} address, 24-bit RGB) between three users:
- the VGA scan-out read path, which has hard priority;
- a built-in clear/fill engine;
- a buffered host write port fed by keyboard/text logic.

It sits between vga_ctrl/frame memory and any pixel writer, and makes the memory's single port the only access point.

Parameters:
ADDR_W, 19, memory address width ({h[9:0], v[8:0]})
DATA_W, 24, pixel width (8R/8G/8B)
FIFO_DEPTH, 8, host write FIFO entries (power of 2, >=2)
CLR_LAST, 524287, last address written by clear engine

Ports:
clk  in  1  single clock
resetn  in  1  reset; one clock; reset is asynchronous and active-low
rd_en  in  1  display read request this cycle
rd_addr  in  ADDR_W  display read address
rd_data  out  DATA_W  read data (= mem_rdata)
rd_data_valid  out  1  rd_data valid for the read issued the previous cycle
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted when wr_valid & wr_ready
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write pixel
clr_start  in  1  pulse: start fill of 0..CLR_LAST
clr_data  in  DATA_W  fill value, sampled on accepted clr_start
clr_busy  out  1  clear engine active
fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held in host FIFO
mem_en  out  1  memory access this cycle
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous read data, one cycle after mem_en & !mem_we

Behaviour:
- Reset values:
  - state IDLE; clear counter 0; FIFO empty.
  - clr_busy=0, rd_data_valid=0, fifo_level=0, wr_ready=0 while resetn low.
  - mem_en, mem_we, mem_addr and mem_wdata all 0.
- Memory-side outputs are combinational from registered state plus the current rd_en. They carry exactly one grant per cycle.
- Grant priority:
  1. rd_en: read, mem_addr=rd_addr.
  2. CLEAR state: write clr_addr/clr_val.
  3. FIFO non-empty: write head entry and pop it.
  4. Otherwise mem_en=0.
- Read latency is 1 cycle: rd_data_valid is registered rd_en, and rd_data=mem_rdata.
- A display read never stalls and never loses a cycle.
- FSM IDLE -> CLEAR on clr_start in IDLE:
  - latch clr_data into clr_val; clr_addr=0; flush FIFO.
  - a host write accepted in that same cycle is also discarded.
  - clr_start in CLEAR is ignored.
- CLEAR behaviour:
  - clr_addr increments only on cycles where the clear write is granted (rd_en=0).
  - the write at clr_addr==CLR_LAST returns the FSM to IDLE.
  - clr_busy is high in CLEAR and drops the cycle after the last fill write.
- wr_ready = (state==IDLE) & !full & resetn. No push when full, even if a pop occurs the same cycle.
- FIFO ordering:
  - FIFO is in-order; fifo_level is updated on push/pop.
  - simultaneous push and pop leaves the level unchanged.
- Host writes to the same address commit in acceptance order.
- A read of an address with a pending FIFO write returns the old memory contents (no forwarding).
- Address wrap: none. clr_addr never exceeds CLR_LAST; out-of-range host addresses are passed through unchecked.
- Reset mid-clear aborts immediately. Memory content is then partially filled and undefined.

Decomposition:
- Package vmem_pkg:
  - ADDR_W, DATA_W and CLR_LAST defaults;
  - state typedef {IDLE, CLEAR};
  - pixel_t (DATA_W) and vaddr_t (ADDR_W) typedefs.
- One sub-module, vmem_wr_fifo:
  - synchronous FIFO with push/pop/flush, full/empty and level outputs;
  - same clk/resetn.
- Arbitration and FSM stay in vmem_arbiter.

Test Plan:
- Reset, then rd_en=1 with rd_addr=0x00005 and mem model holding 0xABCDEF -> next cycle rd_data_valid=1, rd_data=0xABCDEF; all outputs 0 during reset.
- rd_en=1 continuously; push 3 host writes (addr 1,2,3; data 0x111111, 0x222222, 0x333333):
  - fifo_level goes to 3, no mem writes occur;
  - drop rd_en -> writes to 1,2,3 appear in order on consecutive cycles; level returns to 0.
- Push 8 writes with rd_en=1 -> wr_ready=0 after the 8th and fifo_level=8; a 9th wr_valid is held off until the first pop.
- Clear with CLR_LAST=15, 4 writes queued, rd_en low, clr_start with clr_data=0x00FF00:
  - FIFO flushed (level 0);
  - 16 writes at addrs 0..15 with 0x00FF00;
  - clr_busy high for exactly 16 cycles, then low; wr_ready low throughout.
- Clear with rd_en toggling every other cycle -> reads granted on rd_en cycles; clear completes in 32 cycles with no skipped or repeated address; a second clr_start mid-clear is ignored.
- Assert resetn=0 at clr_addr=7 -> clr_busy=0 and mem_en=0 immediately; after release the FSM is IDLE and wr_ready=1.
